char_blit: RTL and testbench

CHAR_BLIT -- requirements
Module: char_blit

---
 rtl/char_blit.sv | 95 +++++++++
 tb/tb_char_blit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/char_blit.sv
// char_blit: draws one 8x8 glyph from a registered-read ROM into a byte-wide frame buffer,
// one scanline per FETCH/WAIT/WRITE pass, with bit-reversed pixel order.
module char_blit #(
  parameter int STRIDE = 80,
  parameter int ROWS   = 60,
  parameter int FB_AW  = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [6:0]       char_code,
  input  logic [6:0]       col,
  input  logic [5:0]       row,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [9:0]       rom_address,
  input  logic [7:0]       rom_q,
  output logic             fb_we,
  output logic [FB_AW-1:0] fb_address,
  output logic [7:0]       fb_data,
  input  logic             fb_ready
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, DONE} state_t;
  state_t           state_q, state_d;
  logic [6:0]       code_q, code_d, col_q, col_d;
  logic [5:0]       row_q, row_d;
  logic [2:0]       line_q, line_d;
  logic             err_q, err_d;
  logic [7:0]       data_q, data_d, rom_rev;
  logic [FB_AW-1:0] fb_addr;
  logic             bad;
  always_comb begin
    for (int i = 0; i < 8; i++) rom_rev[i] = rom_q[7-i];
  end
  assign bad = 32'(col) >= 32'(STRIDE) || 32'(row) >= 32'(ROWS);
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    col_d   = col_q;
    row_d   = row_q;
    line_d  = line_q;
    err_d   = err_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (start) begin
        code_d  = char_code;
        col_d   = col;
        row_d   = row;
        line_d  = 3'd0;
        err_d   = bad;
        state_d = bad ? DONE : FETCH;
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        data_d  = rom_rev;
        state_d = WRITE;
      end
      WRITE: if (fb_ready) begin
        state_d = line_q == 3'd7 ? DONE : FETCH;
        line_d  = line_q + 3'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      col_q   <= col_d;
      row_q   <= row_d;
      line_q  <= line_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end
  // modular FB_AW-wide arithmetic gives the truncated scanline address directly
  assign fb_addr     = (FB_AW'(row_q) * FB_AW'(8) + FB_AW'(line_q)) * FB_AW'(STRIDE) + FB_AW'(col_q);
  assign busy        = state_q != IDLE;
  assign done        = state_q == DONE;
  assign err         = done && err_q;
  assign fb_we       = state_q == WRITE;
  assign fb_address  = fb_we ? fb_addr : '0;
  assign fb_data     = data_q;
  assign rom_address = state_q == FETCH ? {code_q, 3'b000} + {7'd0, line_q} : '0;
endmodule

// File: tb/tb_char_blit.sv
// tb_char_blit: randomized and directed requests checked by a scoreboard fed from a
// behavioural glyph-blit model; a monitor pops expectations on every accepted write and done.
module tb_char_blit;
  localparam int STRIDE = 80, ROWS = 60, FB_AW = 16;
  logic clock = 0, reset_n = 0, start = 0;
  logic [6:0] char_code = 0, col = 0;
  logic [5:0] row = 0;
  logic busy, done, err, fb_we;
  logic [9:0] rom_address;
  logic [7:0] rom_q = 0, fb_data;
  logic [FB_AW-1:0] fb_address;
  logic fb_ready = 1;

  char_blit #(.STRIDE(STRIDE), .ROWS(ROWS), .FB_AW(FB_AW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .char_code(char_code), .col(col), .row(row),
    .busy(busy), .done(done), .err(err), .rom_address(rom_address), .rom_q(rom_q),
    .fb_we(fb_we), .fb_address(fb_address), .fb_data(fb_data), .fb_ready(fb_ready)
  );

  always #5 clock = ~clock;

  logic [7:0] rom_mem [1024];
  always @(posedge clock) rom_q <= rom_mem[rom_address];

  int cyc = 0;
  always @(posedge clock) cyc++;

  int st_lo = 0, st_hi = -1;
  bit rdy_rand = 0;
  always @(posedge clock) begin
    #1;
    fb_ready = (cyc >= st_lo && cyc <= st_hi) ? 1'b0 : (rdy_rand ? ($urandom_range(3) != 0) : 1'b1);
  end

  typedef struct {bit is_done; bit err; logic [15:0] addr; logic [7:0] data;} ev_t;
  ev_t exp_q[$];
  int tests = 0, fails = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // reference model: a valid request paints glyph line l of char code at scanline row*8+l
  function automatic void push_req(int code, int c, int r);
    ev_t e;
    bit rej = c >= STRIDE || r >= ROWS;
    if (!rej)
      for (int l = 0; l < 8; l++) begin
        logic [7:0] b = rom_mem[code * 8 + l];
        e.is_done = 0;
        e.err = 0;
        e.addr = 16'(((r * 8 + l) * STRIDE + c) % 65536);
        for (int i = 0; i < 8; i++) e.data[i] = b[7 - i];
        exp_q.push_back(e);
      end
    e.is_done = 1;
    e.err = rej;
    e.addr = 0;
    e.data = 0;
    exp_q.push_back(e);
  endfunction

  int wr_cnt = 0, done_cnt = 0, done_cyc = 0, rom_nz = 0;
  logic [15:0] last_addr = 0, hold_a = 0;
  logic [7:0] hold_d = 0;
  bit hold_v = 0;

  always @(negedge clock) begin
    ev_t ev;
    if (reset_n) begin
      if (rom_address != 0) rom_nz++;
      if (fb_we) begin
        if (hold_v) begin
          check("stall_addr_stable", 32'(fb_address), 32'(hold_a));
          check("stall_data_stable", 32'(fb_data), 32'(hold_d));
        end
        hold_v = !fb_ready;
        hold_a = fb_address;
        hold_d = fb_data;
        if (fb_ready) begin
          wr_cnt++;
          last_addr = fb_address;
          if (exp_q.size() == 0) check("write_without_expected", 32'(fb_we), 0);
          else begin
            ev = exp_q.pop_front();
            check("write_not_done_slot", 32'(ev.is_done), 0);
            check("write_addr", 32'(fb_address), 32'(ev.addr));
            check("write_data", 32'(fb_data), 32'(ev.data));
          end
        end
      end else hold_v = 0;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_q.size() == 0) check("done_without_expected", 32'(done), 0);
        else begin
          ev = exp_q.pop_front();
          check("done_slot", 32'(ev.is_done), 1);
          check("done_err", 32'(err), 32'(ev.err));
        end
      end
    end
  end

  task automatic request(input int code, input int c, input int r, output int acc);
    int n = 0;
    @(negedge clock);
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("idle_before_request", 32'(busy), 0);
    start = 1;
    char_code = 7'(code);
    col = 7'(c);
    row = 6'(r);
    push_req(code, c, r);
    @(posedge clock);
    #1;
    acc = cyc;
    start = 0;
    char_code = 7'($urandom);
    col = 7'($urandom);
    row = 6'($urandom);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("done_count", 32'(done_cnt), 32'(target));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_fb_we"}, 32'(fb_we), 0);
    check({tag, "_rom_address"}, 32'(rom_address), 0);
    check({tag, "_fb_address"}, 32'(fb_address), 0);
    check({tag, "_fb_data"}, 32'(fb_data), 0);
  endtask

  initial begin
    int acc, d0, w0, r0, n;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 8'($urandom);
    rom_mem[10'h208] = 8'h18;
    rom_mem[10'h209] = 8'h80;
    start = 1;
    #12;
    check_zero_outputs("reset");
    start = 0;
    @(negedge clock);
    reset_n = 1;

    // basic glyph at origin, exact timing
    d0 = done_cnt; w0 = wr_cnt;
    request(8'h41, 0, 0, acc);
    wait_done(d0 + 1, 60);
    check("origin_done_cycle", 32'(done_cyc - acc + 1), 25);
    check("origin_writes", 32'(wr_cnt - w0), 8);

    // bottom-right cell
    d0 = done_cnt; w0 = wr_cnt;
    request(7, 79, 59, acc);
    wait_done(d0 + 1, 60);
    check("corner_last_addr", 32'(last_addr), 38399);
    check("corner_writes", 32'(wr_cnt - w0), 8);

    // out-of-range column and row are rejected at once
    d0 = done_cnt; w0 = wr_cnt; r0 = rom_nz;
    request(8'h41, 80, 0, acc);
    wait_done(d0 + 1, 10);
    check("badcol_done_cycle", 32'(done_cyc - acc + 1), 1);
    check("badcol_writes", 32'(wr_cnt - w0), 0);
    check("badcol_rom", 32'(rom_nz - r0), 0);
    d0 = done_cnt;
    request(8'h41, 3, 60, acc);
    wait_done(d0 + 1, 10);
    check("badrow_done_cycle", 32'(done_cyc - acc + 1), 1);

    // five-cycle stall on line 3
    d0 = done_cnt; w0 = wr_cnt;
    request(8'h41, 12, 7, acc);
    st_lo = acc + 11;
    st_hi = acc + 15;
    wait_done(d0 + 1, 80);
    check("stall_done_cycle", 32'(done_cyc - acc + 1), 30);
    check("stall_writes", 32'(wr_cnt - w0), 8);
    st_lo = 0; st_hi = -1;

    // start while busy is ignored
    d0 = done_cnt;
    request(3, 4, 5, acc);
    repeat (5) @(negedge clock);
    start = 1; char_code = 7'd9; col = 7'd1; row = 6'd1;
    @(negedge clock);
    start = 0;
    wait_done(d0 + 1, 60);
    repeat (40) @(negedge clock);
    check("busy_start_single_done", 32'(done_cnt), 32'(d0 + 1));

    // reset during line 4 aborts cleanly
    d0 = done_cnt; w0 = wr_cnt; n = 0;
    request(8'h41, 5, 10, acc);
    while (wr_cnt < w0 + 4 && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("pre_reset_writes", 32'(wr_cnt - w0), 4);
    @(negedge clock);
    reset_n = 0;
    #1;
    check_zero_outputs("midreset");
    exp_q.delete();
    hold_v = 0;
    repeat (3) @(negedge clock);
    check("midreset_busy_held", 32'(busy), 0);
    reset_n = 1;
    repeat (20) @(negedge clock);
    check("midreset_no_done", 32'(done_cnt), 32'(d0));
    d0 = done_cnt; w0 = wr_cnt;
    request(8'h41, 2, 2, acc);
    wait_done(d0 + 1, 60);
    check("post_reset_done_cycle", 32'(done_cyc - acc + 1), 25);
    check("post_reset_writes", 32'(wr_cnt - w0), 8);

    // randomized requests with random back-pressure
    rdy_rand = 1;
    for (int k = 0; k < 40; k++) begin
      d0 = done_cnt;
      request(int'($urandom_range(127)), int'($urandom_range(85)), int'($urandom_range(63)), acc);
      wait_done(d0 + 1, 400);
    end
    repeat (5) @(negedge clock);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
